// File: rtl/regsum_pkg.sv
// -----------------------------------------------------------------------------
// regsum_pkg
// Shared types and constants for the register-file sum scanner.
//   - regsum_state_e : scanner FSM states (idle, scanning, result pulse)
//   - REGSUM_WIDTH   : default data width, matches the 4-bit register file
//   - REGSUM_SEL_W   : default read-select width
//   - REGSUM_WORDS   : default word count (2**REGSUM_SEL_W)
//   - SUM_W          : default total width; wide enough that a full scan cannot overflow
// -----------------------------------------------------------------------------
package regsum_pkg;

    localparam int unsigned REGSUM_WIDTH = 4;
    localparam int unsigned REGSUM_SEL_W = 2;
    localparam int unsigned REGSUM_WORDS = 4;
    localparam int unsigned SUM_W        = REGSUM_WIDTH + REGSUM_SEL_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StScan = 2'd1,
        StDone = 2'd2
    } regsum_state_e;

endpackage

// File: rtl/regsum_accum.sv
// -----------------------------------------------------------------------------
// regsum_accum
// Running total and running maximum (with index) over a stream of words.
// State updates on the falling edge of clk, like the register file it reads.
// The next-state values are exported so the owner can capture a result that
// already includes the word being sampled on the final edge.
// Ports:
//   clk          : clock (falling-edge active)
//   clr_n        : asynchronous active-low reset
//   i_clear      : synchronous clear of total, max and max index
//   i_en         : accept i_data/i_idx on this edge
//   i_data       : word being sampled
//   i_idx        : index of i_data
//   o_acc_next   : total after this edge
//   o_max_next   : largest word after this edge
//   o_idx_next   : index of that largest word after this edge
// -----------------------------------------------------------------------------
module regsum_accum
    import regsum_pkg::*;
#(
    parameter int unsigned WIDTH = REGSUM_WIDTH,
    parameter int unsigned SEL_W = REGSUM_SEL_W
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     i_clear,
    input  logic                     i_en,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [SEL_W-1:0]         i_idx,
    output logic [WIDTH+SEL_W-1:0]   o_acc_next,
    output logic [WIDTH-1:0]         o_max_next,
    output logic [SEL_W-1:0]         o_idx_next
);

    localparam int unsigned SumW = WIDTH + SEL_W;

    logic [SumW-1:0]  r_acc;
    logic [WIDTH-1:0] r_max;
    logic [SEL_W-1:0] r_idx;

    logic [SumW-1:0]  w_acc_d;
    logic [WIDTH-1:0] w_max_d;
    logic [SEL_W-1:0] w_idx_d;

    always_comb begin
        w_acc_d = r_acc;
        w_max_d = r_max;
        w_idx_d = r_idx;
        if (i_clear) begin
            w_acc_d = '0;
            w_max_d = '0;
            w_idx_d = '0;
        end else if (i_en) begin
            w_acc_d = r_acc + SumW'(i_data);
            // Strict compare: on a tie the earlier (lower) index is kept.
            if (i_data > r_max) begin
                w_max_d = i_data;
                w_idx_d = i_idx;
            end
        end
    end

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_acc <= '0;
            r_max <= '0;
            r_idx <= '0;
        end else begin
            r_acc <= w_acc_d;
            r_max <= w_max_d;
            r_idx <= w_idx_d;
        end
    end

    assign o_acc_next = w_acc_d;
    assign o_max_next = w_max_d;
    assign o_idx_next = w_idx_d;

endmodule

// File: rtl/regfile_sum_scanner.sv
// -----------------------------------------------------------------------------
// regfile_sum_scanner
// Walks the register file read select over every word after a start request,
// then publishes the total, the largest word and its index with a one-cycle
// done pulse. All state changes on the falling edge of clk.
// Optional build macro:
//   REGSUM_CONT_EN : start held high in the result cycle goes straight back to
//                    scanning (period WORDS+1) instead of passing through idle.
// Ports:
//   clk      : clock (falling-edge active)
//   clr_n    : asynchronous active-low reset
//   start    : scan request, honoured only when idle (or in done, see macro)
//   q        : currently selected register-file word
//   msel     : register-file read select (this block is its only driver)
//   busy     : high while scanning
//   done     : one-cycle pulse while the results below are fresh
//   sum      : total of all words of the last completed scan
//   max_word : largest word of the last completed scan
//   max_idx  : index of max_word (lowest index on ties)
// -----------------------------------------------------------------------------
module regfile_sum_scanner
    import regsum_pkg::*;
#(
    parameter int unsigned WIDTH = REGSUM_WIDTH,
    parameter int unsigned WORDS = REGSUM_WORDS,
    parameter int unsigned SEL_W = REGSUM_SEL_W
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       q,
    output logic [SEL_W-1:0]       msel,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH+SEL_W-1:0] sum,
    output logic [WIDTH-1:0]       max_word,
    output logic [SEL_W-1:0]       max_idx
);

    localparam int unsigned     SumW    = WIDTH + SEL_W;
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(WORDS - 1);

    regsum_state_e    r_state;
    regsum_state_e    w_state_next;
    logic [SEL_W-1:0] r_idx;
    logic [SEL_W-1:0] w_idx_next;

    logic [SumW-1:0]  r_sum;
    logic [WIDTH-1:0] r_max_word;
    logic [SEL_W-1:0] r_max_idx;

    logic             w_scanning;
    logic             w_last;
    logic [SumW-1:0]  w_acc_next;
    logic [WIDTH-1:0] w_max_next;
    logic [SEL_W-1:0] w_max_idx_next;

    assign w_scanning = (r_state == StScan);
    assign w_last     = w_scanning && (r_idx == LastIdx);

    // Next-state logic. Scan counter restarts at 0 on every entry into scanning.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        unique case (r_state)
            StIdle: begin
                w_idx_next = '0;
                if (start) begin
                    w_state_next = StScan;
                end
            end
            StScan: begin
                if (r_idx == LastIdx) begin
                    w_state_next = StDone;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + SEL_W'(1);
                end
            end
            StDone: begin
                w_idx_next = '0;
`ifdef REGSUM_CONT_EN
                w_state_next = start ? StScan : StIdle;
`else
                w_state_next = StIdle;
`endif
            end
            default: begin
                w_state_next = StIdle;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= StIdle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // Accumulator is held clear whenever not scanning, so any entry into
    // scanning (from idle or directly from done) starts from zero.
    regsum_accum #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_accum (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_clear    (!w_scanning),
        .i_en       (w_scanning),
        .i_data     (q),
        .i_idx      (r_idx),
        .o_acc_next (w_acc_next),
        .o_max_next (w_max_next),
        .o_idx_next (w_max_idx_next)
    );

    // Results capture the accumulator's next value so the final word sampled
    // on the edge entering done is included.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sum      <= '0;
            r_max_word <= '0;
            r_max_idx  <= '0;
        end else if (w_last) begin
            r_sum      <= w_acc_next;
            r_max_word <= w_max_next;
            r_max_idx  <= w_max_idx_next;
        end
    end

    assign msel     = w_scanning ? r_idx : '0;
    assign busy     = w_scanning;
    assign done     = (r_state == StDone);
    assign sum      = r_sum;
    assign max_word = r_max_word;
    assign max_idx  = r_max_idx;

endmodule

// File: tb/tb_regfile_sum_scanner.sv
// -----------------------------------------------------------------------------
// tb_regfile_sum_scanner
// Directed bench for regfile_sum_scanner. A small register-file model drives q
// combinationally from msel. Inputs change and outputs are sampled just after
// the rising edge, half a cycle away from the active falling edge.
// -----------------------------------------------------------------------------
module tb_regfile_sum_scanner;

    logic       clk;
    logic       clr_n;
    logic       start;
    logic [3:0] q;
    logic [1:0] msel;
    logic       busy;
    logic       done;
    logic [5:0] sum;
    logic [3:0] max_word;
    logic [1:0] max_idx;

    logic [3:0] mem [4];

    int n_cmp;
    int n_err;

    regfile_sum_scanner dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .start    (start),
        .q        (q),
        .msel     (msel),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .max_word (max_word),
        .max_idx  (max_idx)
    );

    assign q = mem[msel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] w0, input logic [3:0] w1,
                        input logic [3:0] w2, input logic [3:0] w3);
        mem[0] = w0;
        mem[1] = w1;
        mem[2] = w2;
        mem[3] = w3;
    endtask

    // One start pulse, then checks the select walk, the done pulse and results.
    // rw >= 0 rewrites word 3 while msel sits at 1.
    task automatic run_scan(input string tag, input logic [5:0] es, input logic [3:0] em,
                            input logic [1:0] ei, input int rw);
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk({tag, "_msel"}, 32'(msel), 32'(i));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            if (i == 1 && rw >= 0) mem[3] = 4'(rw);
            @(posedge clk);
        end
        #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_d"}, 32'(busy), 32'd0);
        chk({tag, "_msel_d"}, 32'(msel), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'(es));
        chk({tag, "_max"}, 32'(max_word), 32'(em));
        chk({tag, "_idx"}, 32'(max_idx), 32'(ei));
        @(posedge clk);
        #1;
        chk({tag, "_done_end"}, 32'(done), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int done_cnt;
        int first_at;
        int second_at;
        int exp_period;

        n_cmp  = 0;
        n_err  = 0;
        start  = 1'b0;
        clr_n  = 1'b1;
        load(4'd0, 4'd0, 4'd0, 4'd0);

        // Reset state
        #1 clr_n = 1'b0;
        #2;
        chk("rst_msel", 32'(msel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_max", 32'(max_word), 32'd0);
        chk("rst_idx", 32'(max_idx), 32'd0);
        @(posedge clk);
        @(posedge clk);
        clr_n = 1'b1;

        // Basic scan: 3+5+9+2 = 19, max 9 at index 2
        load(4'd3, 4'd5, 4'd9, 4'd2);
        run_scan("basic", 6'h13, 4'd9, 2'd2, -1);

        // Results hold while idle
        repeat (3) @(posedge clk);
        #1;
        chk("hold_sum", 32'(sum), 32'h13);
        chk("hold_max", 32'(max_word), 32'd9);

        // All F: 60, tie keeps index 0
        load(4'hF, 4'hF, 4'hF, 4'hF);
        run_scan("allf", 6'h3C, 4'hF, 2'd0, -1);

        // All zero: results zero, exactly one done pulse
        load(4'd0, 4'd0, 4'd0, 4'd0);
        run_scan("zero", 6'h00, 4'd0, 2'd0, -1);
        done_cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("zero_no_extra_done", 32'(done_cnt), 32'd0);

        // Start held high: period between done pulses
        load(4'd3, 4'd5, 4'd9, 4'd2);
`ifdef REGSUM_CONT_EN
        exp_period = 5;
`else
        exp_period = 6;
`endif
        first_at  = -1;
        second_at = -1;
        @(posedge clk);
        start = 1'b1;
        for (int c = 0; c < 40 && second_at < 0; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (first_at < 0) first_at = c;
                else second_at = c;
            end
        end
        start = 1'b0;
        chk("held_two_pulses", 32'(second_at >= 0), 32'd1);
        chk("held_period", 32'(second_at - first_at), 32'(exp_period));
        chk("held_sum", 32'(sum), 32'h13);
        repeat (10) @(posedge clk);

        // Start pulses during SCAN cause no extra scan
        done_cnt = 0;
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("scan_start_ignored", 32'(done_cnt), 32'd1);

        // Mid-scan reset in the third SCAN cycle
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_clr_busy", 32'(busy), 32'd1);
        chk("pre_clr_msel", 32'(msel), 32'd2);
        clr_n = 1'b0;
        #1;
        chk("clr_sum", 32'(sum), 32'd0);
        chk("clr_max", 32'(max_word), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_msel", 32'(msel), 32'd0);
        @(posedge clk);
        clr_n = 1'b1;
        load(4'd1, 4'd1, 4'd1, 4'd1);
        run_scan("ones", 6'd4, 4'd1, 2'd0, -1);

        // Word 3 rewritten 2 -> 7 mid-scan: 3+5+9+7 = 24
        load(4'd3, 4'd5, 4'd9, 4'd2);
        run_scan("rewrite", 6'd24, 4'd9, 2'd2, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
